// File: rtl/uart_pkg.sv
// Shared definitions for the APB-to-UART register bridge: FSM states,
// UART register map indices and the APB data width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [2:0] RBR_THR = 3'd0;
  localparam logic [2:0] IER     = 3'd1;
  localparam logic [2:0] IIR_FCR = 3'd2;
  localparam logic [2:0] LCR     = 3'd3;
  localparam logic [2:0] MCR     = 3'd4;
  localparam logic [2:0] LSR     = 3'd5;
  localparam logic [2:0] MSR     = 3'd6;
  localparam logic [2:0] SCR     = 3'd7;

  localparam int APB_DW = 32;

endpackage

// File: rtl/apb_uart_bridge.sv
// APB3 slave that turns each bus transfer into exactly one UART wr/rd strobe,
// stretching reads with wait states to cover the UART read-data latency.
//
// state   | meaning
// IDLE    | waiting for the first access cycle (psel & penable)
// WR      | uart_wr pulse for one cycle
// RD      | uart_rd pulse for one cycle, wait counter loaded
// RD_WAIT | counting down UART read latency, then capture dout
// DONE    | pready (and pslverr if the address was bad) for one cycle
module apb_uart_bridge
  import uart_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [APB_DW-1:0]   pwdata,
  output logic [APB_DW-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                uart_wr,
  output logic                uart_rd,
  output logic [2:0]          uart_addr,
  output logic [7:0]          uart_din,
  input  logic [7:0]          uart_dout
);

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  prdata_q, prdata_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  logic        hi_err;
  logic        addr_err;
  logic [23:0] unused_pwdata;

  // Upper address bits beyond the 8-register window exist only when ADDR_W > 5.
  if (ADDR_W > 5) begin : g_hi_chk
    assign hi_err = |paddr[ADDR_W-1:5];
  end else begin : g_no_hi_chk
    assign hi_err = 1'b0;
  end

  assign addr_err      = (paddr[1:0] != 2'b00) || hi_err;
  assign unused_pwdata = pwdata[31:8];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    addr_d   = addr_q;
    din_d    = din_q;
    prdata_d = prdata_q;

    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          addr_d = paddr[4:2];
          din_d  = pwdata[7:0];
          if (addr_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = pwrite ? WR : RD;
          end
        end
      end
      WR: begin
        state_d = psel ? DONE : IDLE;
      end
      RD: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          prdata_d = uart_dout;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes and response are registered from the next state so they line up with it.
    wr_d      = (state_d == WR);
    rd_d      = (state_d == RD);
    pready_d  = (state_d == DONE);
    pslverr_d = (state_d == DONE) && err_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      err_q     <= 1'b0;
      addr_q    <= RBR_THR;
      din_q     <= 8'h00;
      prdata_q  <= 8'h00;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      prdata_q  <= prdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata    = {24'h0, prdata_q};
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign uart_wr   = wr_q;
  assign uart_rd   = rd_q;
  assign uart_addr = addr_q;
  assign uart_din  = din_q;

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Directed bench: one bridge with RD_LAT=1 and one with RD_LAT=3 on a shared APB bus.
module tb_apb_uart_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel1 = 1'b0;
  logic        psel3 = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [7:0]  uart_dout = '0;

  logic [31:0] prdata1, prdata3;
  logic        pready1, pready3, pslverr1, pslverr3;
  logic        wr1, wr3, rd1, rd3;
  logic [2:0]  addr1, addr3;
  logic [7:0]  din1, din3;

  int checks = 0;
  int errors = 0;

  int          wr_cnt1 = 0;
  int          rd_cnt1 = 0;
  logic [7:0]  wr_din1 [0:15];
  logic        prev_wr1 = 1'b0, prev_rd1 = 1'b0;
  logic        prev_wr3 = 1'b0, prev_rd3 = 1'b0;

  always #5 clk = ~clk;

  apb_uart_bridge #(.ADDR_W(5), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .uart_wr(wr1), .uart_rd(rd1), .uart_addr(addr1),
    .uart_din(din1), .uart_dout(uart_dout)
  );

  apb_uart_bridge #(.ADDR_W(5), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3), .uart_wr(wr3), .uart_rd(rd3), .uart_addr(addr3),
    .uart_din(din3), .uart_dout(uart_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Strobe monitor: records write data and flags illegal strobe patterns.
  always @(negedge clk) begin
    if (wr1) begin
      if (wr_cnt1 < 16) wr_din1[wr_cnt1] = din1;
      wr_cnt1++;
    end
    if (rd1) rd_cnt1++;
    if ((wr1 && rd1) || (wr3 && rd3)) begin
      errors++;
      $display("FAIL strobe_overlap: wr1=%0b rd1=%0b wr3=%0b rd3=%0b", wr1, rd1, wr3, rd3);
    end
    if ((wr1 && prev_wr1) || (rd1 && prev_rd1) || (wr3 && prev_wr3) || (rd3 && prev_rd3)) begin
      errors++;
      $display("FAIL strobe_repeat: a strobe stayed high two cycles");
    end
    if ((pslverr1 && !pready1) || (pslverr3 && !pready3)) begin
      errors++;
      $display("FAIL pslverr_without_pready");
    end
    prev_wr1 = wr1; prev_rd1 = rd1; prev_wr3 = wr3; prev_rd3 = rd3;
  end

  initial begin
    int wr_base;

    // Reset
    #2;
    mid();
    chk("rst_pready", {31'h0, pready1}, 32'h0);
    chk("rst_prdata", prdata1, 32'h0);
    chk("rst_addr", {29'h0, addr1}, 32'h0);
    chk("rst_din", {24'h0, din1}, 32'h0);
    chk("rst_strobes", {30'h0, wr1, rd1}, 32'h0);
    step();
    rst = 1'b1;
    step();

    // Write 0x83 to LCR (paddr 0x0C)
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h0C; pwdata = 32'h0000_0083;
    mid(); chk("wr_setup_wr", {31'h0, wr1}, 32'h0);
    step(); penable = 1'b1;                                  // A0
    mid(); chk("wr_a0_wr", {31'h0, wr1}, 32'h0);
    step();                                                  // A1
    mid(); chk("wr_a1_wr", {31'h0, wr1}, 32'h1);
    chk("wr_a1_addr", {29'h0, addr1}, 32'h3);
    chk("wr_a1_din", {24'h0, din1}, 32'h83);
    chk("wr_a1_pready", {31'h0, pready1}, 32'h0);
    step();                                                  // A2
    mid(); chk("wr_a2_pready", {31'h0, pready1}, 32'h1);
    chk("wr_a2_pslverr", {31'h0, pslverr1}, 32'h0);
    chk("wr_a2_wr", {31'h0, wr1}, 32'h0);
    step(); psel1 = 1'b0; penable = 1'b0;
    mid(); chk("wr_idle_pready", {31'h0, pready1}, 32'h0);
    chk("wr_pulse_count", wr_cnt1, 32'd1);

    // Read LSR (paddr 0x14), RD_LAT=1, dout 0x60
    step(); psel1 = 1'b1; pwrite = 1'b0; paddr = 5'h14; uart_dout = 8'h60;
    step(); penable = 1'b1;                                  // A0
    mid(); chk("rd1_a0_rd", {31'h0, rd1}, 32'h0);
    step();                                                  // A1
    mid(); chk("rd1_a1_rd", {31'h0, rd1}, 32'h1);
    chk("rd1_a1_addr", {29'h0, addr1}, 32'h5);
    step();                                                  // A2
    mid(); chk("rd1_a2_rd", {31'h0, rd1}, 32'h0);
    chk("rd1_a2_pready", {31'h0, pready1}, 32'h0);
    step();                                                  // A3
    mid(); chk("rd1_a3_pready", {31'h0, pready1}, 32'h1);
    chk("rd1_a3_prdata", prdata1, 32'h0000_0060);
    chk("rd1_a3_pslverr", {31'h0, pslverr1}, 32'h0);
    step(); psel1 = 1'b0; penable = 1'b0;
    chk("rd1_pulse_count", rd_cnt1, 32'd1);

    // Read with RD_LAT=3, dout changes 0x11 -> 0xA5 at A3
    step(); psel3 = 1'b1; pwrite = 1'b0; paddr = 5'h00; uart_dout = 8'h11;
    step(); penable = 1'b1;                                  // A0
    step();                                                  // A1
    mid(); chk("rd3_a1_rd", {31'h0, rd3}, 32'h1);
    step();                                                  // A2
    mid(); chk("rd3_a2_pready", {31'h0, pready3}, 32'h0);
    step(); uart_dout = 8'hA5;                               // A3
    mid(); chk("rd3_a3_pready", {31'h0, pready3}, 32'h0);
    step();                                                  // A4
    mid(); chk("rd3_a4_pready", {31'h0, pready3}, 32'h0);
    chk("rd3_a4_prdata_old", prdata3, 32'h0);
    step();                                                  // A5
    mid(); chk("rd3_a5_pready", {31'h0, pready3}, 32'h1);
    chk("rd3_a5_prdata", prdata3, 32'h0000_00A5);
    step(); psel3 = 1'b0; penable = 1'b0;

    // Misaligned write (paddr 0x0D) is rejected with pslverr at A1
    wr_base = wr_cnt1;
    step(); psel1 = 1'b1; pwrite = 1'b1; paddr = 5'h0D; pwdata = 32'h0000_00FF;
    step(); penable = 1'b1;                                  // A0
    mid(); chk("err_a0_pready", {31'h0, pready1}, 32'h0);
    step();                                                  // A1
    mid(); chk("err_a1_pready", {31'h0, pready1}, 32'h1);
    chk("err_a1_pslverr", {31'h0, pslverr1}, 32'h1);
    chk("err_a1_wr", {31'h0, wr1}, 32'h0);
    chk("err_a1_prdata", prdata1, 32'h0000_0060);
    step(); psel1 = 1'b0; penable = 1'b0;
    mid(); chk("err_after_pslverr", {31'h0, pslverr1}, 32'h0);
    chk("err_no_wr", wr_cnt1 - wr_base, 32'd0);

    // Back-to-back writes to THR: 0x41 then 0x42, 4-cycle spacing
    wr_base = wr_cnt1;
    step(); psel1 = 1'b1; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h0000_0041;
    step(); penable = 1'b1;                                  // A0
    step();                                                  // A1
    step();                                                  // A2
    mid(); chk("b2b_first_pready", {31'h0, pready1}, 32'h1);
    step(); penable = 1'b0; pwdata = 32'h0000_0042;           // setup of second
    step(); penable = 1'b1;                                  // A0
    step();                                                  // A1
    mid(); chk("b2b_second_din", {24'h0, din1}, 32'h42);
    step();                                                  // A2
    mid(); chk("b2b_second_pready", {31'h0, pready1}, 32'h1);
    step(); psel1 = 1'b0; penable = 1'b0;
    chk("b2b_pulse_count", wr_cnt1 - wr_base, 32'd2);
    chk("b2b_din0", {24'h0, wr_din1[wr_base]}, 32'h41);
    chk("b2b_din1", {24'h0, wr_din1[wr_base+1]}, 32'h42);

    // Async reset during RD_WAIT, then a clean read afterwards
    step(); psel3 = 1'b1; pwrite = 1'b0; paddr = 5'h18; uart_dout = 8'h77;
    step(); penable = 1'b1;                                  // A0
    step();                                                  // A1
    step();                                                  // A2 (RD_WAIT)
    #2 rst = 1'b0;
    #1;
    chk("arst_pready", {31'h0, pready3}, 32'h0);
    chk("arst_rd", {31'h0, rd3}, 32'h0);
    chk("arst_prdata", prdata3, 32'h0);
    chk("arst_addr", {29'h0, addr3}, 32'h0);
    psel3 = 1'b0; penable = 1'b0;
    step(); rst = 1'b1;
    step(); psel3 = 1'b1; pwrite = 1'b0; paddr = 5'h1C; uart_dout = 8'h3C;
    step(); penable = 1'b1;                                  // A0
    step();                                                  // A1
    mid(); chk("post_rst_rd", {31'h0, rd3}, 32'h1);
    chk("post_rst_addr", {29'h0, addr3}, 32'h7);
    step(); step(); step();                                  // A2..A4
    mid(); chk("post_rst_a4_pready", {31'h0, pready3}, 32'h0);
    step();                                                  // A5
    mid(); chk("post_rst_pready", {31'h0, pready3}, 32'h1);
    chk("post_rst_prdata", prdata3, 32'h0000_003C);
    step(); psel3 = 1'b0; penable = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
